// File: rtl/store_buffer.sv
// MEM-stage store buffer: formats SB/SH/SW stores into word-aligned entries,
// queues them in a FIFO and drains them to the data-memory write port.
module store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    st_valid,
  input  logic [5:0]              instruccion,
  input  logic [31:0]             st_addr,
  input  logic [31:0]             st_data,
  input  logic                    ld_valid,
  input  logic [31:0]             ld_addr,
  output logic                    stall,
  output logic                    misaligned,
  output logic                    mem_wr_valid,
  input  logic                    mem_wr_ready,
  output logic [31:0]             mem_addr,
  output logic [31:0]             mem_wdata,
  output logic [3:0]              mem_be,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [29:0] word;
    logic [31:0] wdata;
    logic [3:0]  be;
  } entry_t;

  entry_t          fifo_q [DEPTH];
  entry_t          new_e;
  entry_t          head_e;
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic            is_sb;
  logic            is_sh;
  logic            is_sw;
  logic            is_store;
  logic            aligned;
  logic            legal;
  logic            full;
  logic            push;
  logic            pop;
  logic            hit;
  logic            unused_ld_lsbs;

  assign is_sb    = (instruccion == 6'b101000);
  assign is_sh    = (instruccion == 6'b101001);
  assign is_sw    = (instruccion == 6'b101011);
  assign is_store = st_valid & (is_sb | is_sh | is_sw);
  assign aligned  = is_sb | (is_sh & ~st_addr[0]) | (is_sw & (st_addr[1:0] == 2'b00));
  assign legal    = is_store & aligned;
  assign full     = (count == CW'(DEPTH));
  assign push     = legal & ~full;
  assign pop      = mem_wr_valid & mem_wr_ready;

  // Hazard matching is word-granular, so the load's byte offset is irrelevant.
  assign unused_ld_lsbs = ^ld_addr[1:0];

  // Lane replication and byte-enable generation for the incoming store.
  always_comb begin
    new_e.word  = st_addr[31:2];
    new_e.wdata = st_data;
    new_e.be    = 4'b1111;
    if (is_sb) begin
      new_e.wdata = {4{st_data[7:0]}};
      new_e.be    = 4'b0001 << st_addr[1:0];
    end else if (is_sh) begin
      new_e.wdata = {2{st_data[15:0]}};
      new_e.be    = st_addr[1] ? 4'b1100 : 4'b0011;
    end
  end

  // An entry is live when its distance from head is below the occupancy.
  always_comb begin
    logic [PW-1:0] off;
    off = '0;
    hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off = PW'(i) - head;
      if (({1'b0, off} < count) && (fifo_q[PW'(i)].word == ld_addr[31:2])) begin
        hit = 1'b1;
      end
    end
  end

  assign stall = (legal & full) | (ld_valid & hit);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      misaligned <= 1'b0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      if (push & ~pop) begin
        count <= count + CW'(1);
      end else if (pop & ~push) begin
        count <= count - CW'(1);
      end
      misaligned <= is_store & ~aligned;
    end
  end

  // Payload storage needs no reset; occupancy gates everything that reads it.
  always_ff @(posedge clk) begin
    if (rst_n && push) fifo_q[tail] <= new_e;
  end

  assign head_e       = fifo_q[head];
  assign mem_wr_valid = (count != '0);
  assign mem_addr     = mem_wr_valid ? {head_e.word, 2'b00} : 32'h0;
  assign mem_wdata    = mem_wr_valid ? head_e.wdata : 32'h0;
  assign mem_be       = mem_wr_valid ? head_e.be : 4'h0;

endmodule

// File: doc/store_buffer.md
# store_buffer

Write-side buffer in the MEM stage of the pipelined MIPS core, directly downstream of the store-data formatting stage (SB/SH/SW). It accepts one formatted store per cycle and converts it to a word-aligned address, replicated write data and 4-bit byte enables. It queues the store in a small FIFO and drains it to the data-memory write port over a valid/ready handshake. It stalls the pipeline when full, or when a load in MEM hits a pending store's word.

## Interface
- DEPTH, 4, number of FIFO entries; power of two, ≥2
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock, reset is synchronous and active-low
- st_valid  in  1  store present in MEM stage this cycle
- instruccion  in  6  opcode: 101000 SB, 101001 SH, 101011 SW; any other opcode is not a store
- st_addr  in  32  byte address of the store
- st_data  in  32  store data from the formatting stage; low byte/half meaningful for SB/SH
- ld_valid  in  1  load present in MEM stage
- ld_addr  in  32  load byte address
- stall  out  1  combinational; holds IF..MEM this cycle
- misaligned  out  1  registered one-cycle pulse: SH/SW store dropped for misalignment
- mem_wr_valid  out  1  head entry valid toward data memory
- mem_wr_ready  in  1  data memory accepts head this cycle
- mem_addr  out  32  word address of head, bits [1:0] always 0
- mem_wdata  out  32  write data of head
- mem_be  out  4  byte enables of head; bit i covers mem_wdata[8i+7:8i]
- count  out  log2(DEPTH)+1  current occupancy

## Operation
- Legal store: st_valid=1, opcode SB/SH/SW, aligned (SH: addr[0]=0; SW: addr[1:0]=0; SB always aligned).
- Lane generation, with a = st_addr[1:0]:
  - SB: be = 1<<a; wdata = {4{st_data[7:0]}}.
  - SH: be = a[1] ? 1100 : 0011; wdata = {2{st_data[15:0]}}.
  - SW: be = 1111; wdata = st_data.
  - In all cases entry addr = {st_addr[31:2],2'b00}.
- Push: a legal store is written at the tail when count<DEPTH.
- Full: a legal store arriving with count==DEPTH is not written; stall=1. The pipeline holds its inputs stable and the store retries next cycle.
- Misaligned SH/SW with st_valid: not written, no stall; misaligned=1 next cycle.
- Non-store opcode with st_valid: ignored.
- Drain: mem_wr_valid=1 iff count>0. mem_addr/mem_wdata/mem_be reflect the head entry. Pop on mem_wr_valid & mem_wr_ready.
- mem_* outputs are stable while mem_wr_valid=1 and ready=0.
- Load hazard: stall=1 when ld_valid=1 and any occupied entry has addr[31:2]==ld_addr[31:2]. The hazard ignores byte enables (word granularity). It clears once the matching entries drain.
- stall = (legal store & count==DEPTH) | load hazard.
- Ordering: strict FIFO. Entries never merge or reorder.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.

## Timing
- Reset (rst_n=0 at a rising edge): count=0, head/tail=0, mem_wr_valid=0, mem_addr=0, mem_wdata=0, mem_be=0, misaligned=0.
- During reset, stall=0 because no entries are occupied. Reset mid-drain discards all entries with no partial write.
- Latency: a store pushed at edge N into an empty buffer gives mem_wr_valid=1 in cycle N+1. There is no combinational path from st_* to mem_*.
- Simultaneous push and pop: count unchanged. A push into an empty buffer with no pop follows the latency rule above.
- At count==DEPTH with a pop in the same cycle, stall is still 1 and the push is rejected. The store is accepted on the following edge, when count==DEPTH-1.
- Hazard check uses entries occupied at the start of the cycle. An entry popped in the same cycle still counts.
- A store pushed in the same cycle as a matching load is not checked; the load precedes it in program order.
- count updates on the same edge as push/pop.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with random inputs -> all outputs 0, count=0, stall=0.
- Lanes: SB addr 0x103 data 0x000000A5 -> mem_addr 0x100, be 1000, wdata 0xA5A5A5A5. SH addr 0x102 data 0xFFFF8001 -> be 1100, wdata 0x80018001. SW addr 0x200 data 0x12345678 -> be 1111. Each store appears one cycle after push.
- Full/backpressure: 5 consecutive SW with mem_wr_ready=0 -> count=4, stall=1 on the 5th. Raise ready for one cycle -> 5th store accepted the next cycle. Drain order matches issue order.
- Misaligned: SW addr 0x102 -> no push, count unchanged, stall=0, misaligned=1 for exactly one cycle.
- Load hazard: SB addr 0x40 pending, ready=0, LW ld_addr 0x43 -> stall=1. LW ld_addr 0x44 -> stall=0. Raise ready -> stall drops the cycle after the pop.
- Wrap and concurrency: 20 stores with ready toggling every cycle -> memory writes in order, pointers wrap correctly, count never exceeds 4.
